// File: rtl/oven_input_conditioner_pkg.sv
// Shared constants and hold-FSM state encoding for the oven button front end.
package oven_input_conditioner_pkg;

  localparam int SECOND = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } hold_state_t;

endpackage

// File: rtl/oven_input_conditioner_debouncer.sv
// One push-button channel: 2-FF synchroniser, debounce counter, press pulse.
module button_debouncer
  import oven_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE = SECOND / 50
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed_level,
  output logic o_press_pulse
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1    <= i_key_n;
      r_s2    <= r_s1;
      r_pulse <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        // Accept the new level; only a 1->0 transition is a press.
        r_stable <= r_s2;
        r_cnt    <= '0;
        r_pulse  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pressed_level = ~r_stable;
  assign o_press_pulse   = r_pulse;

endmodule

// File: rtl/oven_input_conditioner.sv
// Button front end: three debounced press pulses plus a hotter+colder long-hold pulse.
module oven_input_conditioner
  import oven_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE = SECOND / 50,
  parameter int HOLD     = 3 * SECOND
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_start_n,
  input  logic i_key_colder_n,
  input  logic i_key_hotter_n,
  output logic o_start,
  output logic o_colder,
  output logic o_hotter,
  output logic o_buttons_held
);

  localparam int HW = $clog2(HOLD);

  logic w_unused_start_level;
  logic w_colder_level;
  logic w_hotter_level;
  logic w_both;

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_start (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_key_n         (i_key_start_n),
    .o_pressed_level (w_unused_start_level),
    .o_press_pulse   (o_start)
  );

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_colder (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_key_n         (i_key_colder_n),
    .o_pressed_level (w_colder_level),
    .o_press_pulse   (o_colder)
  );

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_hotter (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_key_n         (i_key_hotter_n),
    .o_pressed_level (w_hotter_level),
    .o_press_pulse   (o_hotter)
  );

  assign w_both = w_colder_level & w_hotter_level;

  hold_state_t   r_state;
  hold_state_t   w_next_state;
  logic [HW-1:0] r_hcnt;
  logic [HW-1:0] w_next_hcnt;
  logic          r_held;
  logic          w_next_held;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_hcnt  <= w_next_hcnt;
      r_held  <= w_next_held;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_hcnt  = r_hcnt;
    w_next_held  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_both) begin
          w_next_state = COUNT;
          w_next_hcnt  = '0;
        end
      end
      COUNT: begin
        if (!w_both) begin
          w_next_state = IDLE;
        end else if (r_hcnt == HW'(HOLD - 2)) begin
          w_next_held  = 1'b1;
          w_next_state = FIRED;
        end else begin
          w_next_hcnt = r_hcnt + HW'(1);
        end
      end
      FIRED: begin
        // Re-arm only after both keys are fully released.
        if (!w_colder_level && !w_hotter_level) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_buttons_held = r_held;

endmodule

// File: tb/tb_oven_input_conditioner.sv
// Directed bench for oven_input_conditioner with a per-cycle expected-pulse scoreboard.
module tb_oven_input_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int LAT = D + 2;

  localparam logic [3:0] M_START = 4'b0001;
  localparam logic [3:0] M_COLD  = 4'b0010;
  localparam logic [3:0] M_HOT   = 4'b0100;
  localparam logic [3:0] M_HELD  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;

  logic clk;
  logic rst;
  logic key_start_n;
  logic key_colder_n;
  logic key_hotter_n;
  logic start;
  logic colder;
  logic hotter;
  logic buttons_held;

  exp_t       sb[$];
  int         cyc;
  int         errors;
  int         checks;
  int         n;
  logic [3:0] exp_m;
  logic [3:0] obs;

  oven_input_conditioner #(.DEBOUNCE(D), .HOLD(H)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_key_start_n  (key_start_n),
    .i_key_colder_n (key_colder_n),
    .i_key_hotter_n (key_hotter_n),
    .o_start        (start),
    .o_colder       (colder),
    .o_hotter       (hotter),
    .o_buttons_held (buttons_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int c, input logic [3:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic tick(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      exp_m = 4'b0000;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_m = sb[0].mask;
        void'(sb.pop_front());
      end
      obs = {buttons_held, hotter, colder, start};
      checks++;
      assert (obs === exp_m) else begin
        errors++;
        $error("FAIL outputs cyc=%0d observed=%b expected=%b (held,hot,cold,start)", cyc, obs, exp_m);
      end
    end
  endtask

  initial begin
    cyc    = 0;
    errors = 0;
    checks = 0;
    rst          = 1'b1;
    key_start_n  = 1'b1;
    key_colder_n = 1'b1;
    key_hotter_n = 1'b1;

    // Reset and idle
    tick(3);
    rst = 1'b0;
    tick(20);

    // Clean start press, then release
    key_start_n = 1'b0;
    push(cyc + LAT, M_START);
    tick(15);
    key_start_n = 1'b1;
    tick(15);

    // Bouncy hotter press and bouncy release
    for (int p = 0; p < 6; p++) begin
      key_hotter_n = (p % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_hotter_n = 1'b0;
    push(cyc + LAT, M_HOT);
    tick(15);
    for (int p = 0; p < 6; p++) begin
      key_hotter_n = (p % 2 == 0) ? 1'b1 : 1'b0;
      tick(2);
    end
    key_hotter_n = 1'b1;
    tick(15);

    // Long combo hold; start pressed so its pulse lands with buttons_held
    n = cyc;
    key_hotter_n = 1'b0;
    key_colder_n = 1'b0;
    push(n + LAT, M_HOT | M_COLD);
    push(n + LAT + H, M_HELD | M_START);
    tick(10);
    key_start_n = 1'b0;
    tick(30);
    key_hotter_n = 1'b1;
    key_colder_n = 1'b1;
    key_start_n  = 1'b1;
    tick(20);

    // Short combo: colder let go early, no hold pulse
    n = cyc;
    key_hotter_n = 1'b0;
    key_colder_n = 1'b0;
    push(n + LAT, M_HOT | M_COLD);
    tick(LAT + 1);
    key_colder_n = 1'b1;
    tick(15);
    key_hotter_n = 1'b1;
    tick(15);

    // Re-press after full release re-arms
    n = cyc;
    key_hotter_n = 1'b0;
    key_colder_n = 1'b0;
    push(n + LAT, M_HOT | M_COLD);
    push(n + LAT + H, M_HELD);
    tick(25);
    key_hotter_n = 1'b1;
    key_colder_n = 1'b1;
    tick(15);

    // Reset while hold count is at 5, keys stay pressed
    n = cyc;
    key_hotter_n = 1'b0;
    key_colder_n = 1'b0;
    push(n + LAT, M_HOT | M_COLD);
    tick(LAT + 6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    push(cyc + LAT, M_HOT | M_COLD);
    push(cyc + LAT + H, M_HELD);
    tick(30);
    key_hotter_n = 1'b1;
    key_colder_n = 1'b1;
    tick(15);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0 pending entries", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
